// File: rtl/txbuf_pkg.sv
// Shared types and geometry for the transmit ping-pong buffer.
package txbuf_pkg;

  localparam int BANK_BYTES = 1024;
  localparam int OFS_W      = 10;
  localparam int ADDR_W     = 11;
  localparam int GAP_W      = 12;

  typedef enum logic [1:0] {FILL, FULL, COMMIT, PAD} txbuf_state_t;

endpackage

// File: rtl/txbuf_dpram.sv
// Simple dual-port RAM: one write port, one registered read port, single clock.
module txbuf_dpram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [0:(2**ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Array contents are never reset; only the output register is.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/tx_pingpong_buf.sv
// Byte-stream packer into two 1024-byte banks feeding the frame transmitter.
// Optional partial-bank flush after an idle timeout: define TXBUF_FLUSH_EN.
module tx_pingpong_buf
  import txbuf_pkg::*;
#(
  parameter int          GAP_MIN       = 1070,
  parameter int          FLUSH_TIMEOUT = 2000,
  parameter logic [7:0]  PAD_BYTE      = 8'h00
) (
  input  logic              clk125,
  input  logic              rst_n,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] txad,
  output logic [7:0]        data1,
  output logic              idx,
  output logic [15:0]       frames
);

  localparam logic [OFS_W-1:0] LAST_OFS = OFS_W'(BANK_BYTES - 1);
  localparam logic [GAP_W-1:0] GAP_MAX  = '1;
  localparam logic [GAP_W-1:0] GAP_THR  = GAP_W'(GAP_MIN);

  txbuf_state_t     state_reg, state_next;
  logic [OFS_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [GAP_W-1:0] gap_cnt_reg, gap_cnt_next;
  logic             idx_reg, idx_next;
  logic [15:0]      frames_reg, frames_next;
  logic             in_ready_reg, in_ready_next;
  logic             accept;
  logic             we;
  logic [7:0]       wdata;

`ifdef TXBUF_FLUSH_EN
  localparam int IDLE_W = $clog2(FLUSH_TIMEOUT + 1);
  localparam logic [IDLE_W-1:0] IDLE_THR = IDLE_W'(FLUSH_TIMEOUT - 1);
  logic [IDLE_W-1:0] idle_cnt_reg, idle_cnt_next;
`endif

  assign accept = in_valid && in_ready_reg;

  always_ff @(posedge clk125 or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= FILL;
      wr_ptr_reg   <= '0;
      gap_cnt_reg  <= GAP_THR;
      idx_reg      <= 1'b0;
      frames_reg   <= '0;
      in_ready_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wr_ptr_reg   <= wr_ptr_next;
      gap_cnt_reg  <= gap_cnt_next;
      idx_reg      <= idx_next;
      frames_reg   <= frames_next;
      in_ready_reg <= in_ready_next;
    end
  end

`ifdef TXBUF_FLUSH_EN
  always_ff @(posedge clk125 or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt_reg <= '0;
    end else begin
      idle_cnt_reg <= idle_cnt_next;
    end
  end

  always_comb begin
    idle_cnt_next = '0;
    if (state_reg == FILL && wr_ptr_reg != '0 && !accept) begin
      idle_cnt_next = idle_cnt_reg + 1'b1;
    end
  end
`endif

  always_comb begin
    state_next   = state_reg;
    wr_ptr_next  = wr_ptr_reg;
    gap_cnt_next = (gap_cnt_reg == GAP_MAX) ? gap_cnt_reg : gap_cnt_reg + 1'b1;
    idx_next     = idx_reg;
    frames_next  = frames_reg;
    we           = 1'b0;
    wdata        = in_data;

    case (state_reg)
      FILL: begin
        if (accept) begin
          we = 1'b1;
          // Offset 1023 is held; the wrap to 0 comes only from COMMIT.
          if (wr_ptr_reg == LAST_OFS) begin
            state_next = FULL;
          end else begin
            wr_ptr_next = wr_ptr_reg + 1'b1;
          end
        end
`ifdef TXBUF_FLUSH_EN
        else if (wr_ptr_reg != '0 && idle_cnt_reg >= IDLE_THR) begin
          state_next = PAD;
        end
`endif
      end
      FULL: begin
        if (gap_cnt_reg >= GAP_THR) begin
          state_next = COMMIT;
        end
      end
      COMMIT: begin
        idx_next     = ~idx_reg;
        frames_next  = frames_reg + 1'b1;
        wr_ptr_next  = '0;
        gap_cnt_next = '0;
        state_next   = FILL;
      end
      PAD: begin
`ifdef TXBUF_FLUSH_EN
        we    = 1'b1;
        wdata = PAD_BYTE;
        if (wr_ptr_reg == LAST_OFS) begin
          state_next = FULL;
        end else begin
          wr_ptr_next = wr_ptr_reg + 1'b1;
        end
`else
        state_next = FILL;
`endif
      end
      default: state_next = FILL;
    endcase

    in_ready_next = (state_next == FILL);
  end

  txbuf_dpram #(
    .DATA_W (8),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk125),
    .rst_n (rst_n),
    .we    (we),
    .waddr ({~idx_reg, wr_ptr_reg}),
    .wdata (wdata),
    .raddr (txad),
    .rdata (data1)
  );

  assign in_ready = in_ready_reg;
  assign idx      = idx_reg;
  assign frames   = frames_reg;

endmodule

// File: tb/tb_tx_pingpong_buf.sv
// Scoreboard bench for tx_pingpong_buf: directed fill, stream, stall and reset scenarios.
`timescale 1ns/1ps
module tb_tx_pingpong_buf;

  localparam int GAP_MIN       = 1070;
  localparam int FLUSH_TIMEOUT = 2000;
  localparam int BANK          = 1024;

  logic        clk125 = 1'b0;
  logic        rst_n  = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [10:0] txad = '0;
  logic [7:0]  data1;
  logic        idx;
  logic [15:0] frames;

  always #4 clk125 = ~clk125;

  tx_pingpong_buf #(
    .GAP_MIN       (GAP_MIN),
    .FLUSH_TIMEOUT (FLUSH_TIMEOUT),
    .PAD_BYTE      (8'h00)
  ) dut (
    .clk125   (clk125),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .txad     (txad),
    .data1    (data1),
    .idx      (idx),
    .frames   (frames)
  );

  int checks = 0;
  int failures = 0;
  int unsigned cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pat(input int kind, input int n);
    logic [31:0] v;
    v = n * 7 + 3;
    case (kind)
      0:       return 8'(n);
      1:       return v[7:0];
      default: return ((n % BANK) < 512) ? v[7:0] : 8'h00;
    endcase
  endfunction

  always @(posedge clk125) cyc <= cyc + 1;

  // Toggle monitor: records the clock edge at which idx changed (reset-induced changes ignored).
  int unsigned tog_q[$];
  logic idx_prev = 1'b0;
  always @(negedge clk125) begin
    if (rst_n && idx !== idx_prev) tog_q.push_back(cyc);
    idx_prev = idx;
  end

  // Read scoreboard: expected byte queued when the address is driven, compared one cycle later.
  logic [7:0]  exp_q[$];
  logic [10:0] adr_q[$];
  logic rd_req = 1'b0;
  logic rd_seen = 1'b0;
  always @(posedge clk125) rd_seen <= rd_req;
  always @(negedge clk125) begin
    if (rd_seen) begin
      if (exp_q.size() == 0) begin
        check("rd_unexpected", 32'(data1), 32'hFFFF_FFFF);
      end else begin
        logic [7:0]  e;
        logic [10:0] a;
        e = exp_q.pop_front();
        a = adr_q.pop_front();
        checks++;
        if (data1 !== e) begin
          failures++;
          $display("FAIL rd_data addr=%0h actual=%0h required=%0h", a, data1, e);
        end
      end
    end
  end

  int stall_q[$];

  task automatic send(input int n, input int kind, input int base, output int unsigned last);
    int k = 0;
    int guard = 0;
    int stall_run = 0;
    logic acc;
    last = 0;
    stall_q.delete();
    in_valid = 1'b1;
    in_data  = pat(kind, base);
    while (k < n && guard < n + 20000) begin
      @(negedge clk125);
      acc = in_ready;
      @(posedge clk125);
      #1;
      guard++;
      if (acc) begin
        if (k > 0 && (k % BANK) == 0) stall_q.push_back(stall_run);
        stall_run = 0;
        last = cyc;
        k++;
        if (k < n) in_data = pat(kind, base + k);
      end else begin
        stall_run++;
      end
    end
    in_valid = 1'b0;
    check("send_complete", 32'(k), 32'(n));
  endtask

  task automatic read_bank(input logic bank, input int kind, input int base);
    for (int o = 0; o < BANK; o++) begin
      txad   = {bank, 10'(o)};
      rd_req = 1'b1;
      exp_q.push_back(pat(kind, base + o));
      adr_q.push_back({bank, 10'(o)});
      @(posedge clk125);
      #1;
    end
    rd_req = 1'b0;
  endtask

  task automatic read1(input logic [10:0] a, input logic [7:0] e);
    txad   = a;
    rd_req = 1'b1;
    exp_q.push_back(e);
    adr_q.push_back(a);
    @(posedge clk125);
    #1;
    rd_req = 1'b0;
  endtask

  task automatic wait_tog(input int target, input int budget);
    int n = 0;
    while (tog_q.size() < target && n < budget) begin
      @(posedge clk125);
      #1;
      n++;
    end
    @(negedge clk125);
    check("toggle_seen", 32'(tog_q.size() >= target), 32'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk125);
      #1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned last;
    int n0;

    // Reset state.
    idle(3);
    @(negedge clk125);
    check("rst_idx", 32'(idx), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_frames", 32'(frames), 32'd0);
    check("rst_data1", 32'(data1), 32'd0);
    rst_n = 1'b1;
    idle(1);
    check("ready_after_rst", 32'(in_ready), 32'd1);

    // First bank: ready drops after byte 1023, idx toggles two edges later.
    send(BANK, 0, 0, last);
    @(negedge clk125);
    check("ready_low_full", 32'(in_ready), 32'd0);
    wait_tog(1, 20);
    check("tog1_time", tog_q[0], last + 2);
    check("tog1_idx", 32'(idx), 32'd1);
    check("tog1_frames", 32'(frames), 32'd1);
    read1({1'b1, 10'd5}, 8'h05);
    read1({1'b1, 10'd255}, 8'hFF);
    read1({1'b1, 10'd1023}, 8'hFF);

    // Continuous 3 banks; bank 1 (old pattern) is read while bank 0 fills.
    n0 = tog_q.size();
    fork
      send(3 * BANK, 1, 0, last);
      begin
        read_bank(1'b1, 0, 0);
        for (int j = 0; j < 3; j++) begin
          wait_tog(n0 + j + 1, 3000);
          read_bank(idx, 1, j * BANK);
        end
      end
    join
    check("stream_tog_count", 32'(tog_q.size()), 32'(n0 + 3));
    // Toggle edges sit GAP_MIN cycles of counting after the clear, plus FULL and COMMIT.
    check("stream_gap2", tog_q[n0 + 1] - tog_q[n0], 32'(GAP_MIN + 2));
    check("stream_gap3", tog_q[n0 + 2] - tog_q[n0 + 1], 32'(GAP_MIN + 2));
    check("stream_stall", 32'(stall_q.size() > 1 ? stall_q[1] : -1), 32'(GAP_MIN + 2 - BANK));
    check("stream_frames", 32'(frames), 32'd4);

    // Stalled producer.
    n0 = tog_q.size();
    send(512, 1, 0, last);
    idle(5000);
`ifdef TXBUF_FLUSH_EN
    check("flush_tog_count", 32'(tog_q.size()), 32'(n0 + 1));
    check("flush_tog_time", tog_q.size() > n0 ? tog_q[n0] : 0, last + FLUSH_TIMEOUT + 512 + 2);
    read_bank(idx, 2, 0);
`else
    check("stall_no_toggle", 32'(tog_q.size()), 32'(n0));
    send(512, 1, 512, last);
    wait_tog(n0 + 1, 20);
    check("stall_tog_time", tog_q[n0], last + 2);
    read_bank(idx, 1, 0);
`endif
    check("stall_frames", 32'(frames), 32'd5);

    // Reset mid-fill at byte 300.
    txad = {1'b1, 10'd5};
    idle(2);
    @(negedge clk125);
    check("pre_rst_data1", 32'(data1), 32'h26);
    check("pre_rst_idx", 32'(idx), 32'd1);
    send(300, 0, 0, last);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_idx", 32'(idx), 32'd0);
    check("arst_frames", 32'(frames), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd0);
    check("arst_data1", 32'(data1), 32'd0);
    idle(2);
    @(negedge clk125);
    rst_n = 1'b1;
    idle(1);
    n0 = tog_q.size();
    send(BANK - 1, 0, 0, last);
    idle(10);
    check("rst_no_early_tog", 32'(tog_q.size()), 32'(n0));
    send(1, 0, BANK - 1, last);
    wait_tog(n0 + 1, 20);
    check("rst_tog_time", tog_q[n0], last + 2);
    check("rst_frames_after", 32'(frames), 32'd1);
    check("rst_idx_after", 32'(idx), 32'd1);
    read_bank(1'b1, 0, 0);

    idle(4);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
